// File: rtl/bec_ctrl_pkg.sv
// Shared encodings and width helpers for the BEC host controller slice.
package bec_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE_CHUNK = 2'd0,
        CMD_START       = 2'd1,
        CMD_READ_REQ    = 2'd2,
        CMD_ABORT       = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_PUSH    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_PROC    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_READ    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_SEQ = 2'd1,
        ERR_OVF     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    // Index width for a range of n entries; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of host words needed to carry one field element.
    function automatic int unsigned nchunk(input int unsigned fw, input int unsigned cw);
        return (fw + cw - 1) / cw;
    endfunction

endpackage

// File: rtl/bec_chunk_unpacker.sv
// Selects one CHUNK_W slice of a FIELD_W vector, zero-padded above FIELD_W.
module bec_chunk_unpacker
    import bec_ctrl_pkg::*;
#(
    parameter int unsigned FIELD_W = 163,
    parameter int unsigned CHUNK_W = 64
)(
    input  logic [FIELD_W-1:0]                              i_vec,
    input  logic [idx_w(nchunk(FIELD_W, CHUNK_W))-1:0]      i_idx,
    output logic [CHUNK_W-1:0]                              o_chunk,
    output logic                                            o_last
);

    localparam int unsigned NCHUNK = nchunk(FIELD_W, CHUNK_W);
    localparam int unsigned CIDX_W = idx_w(NCHUNK);
    localparam int unsigned PAD_W  = NCHUNK * CHUNK_W;

    logic [PAD_W-1:0] w_pad;

    // Pad the vector to whole chunks and pick the indexed one.
    always_comb begin
        w_pad              = '0;
        w_pad[FIELD_W-1:0] = i_vec;
        o_chunk            = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (i_idx == CIDX_W'(k)) begin
                o_chunk = w_pad[k*CHUNK_W +: CHUNK_W];
            end
        end
        o_last = (i_idx == CIDX_W'(NCHUNK - 1));
    end

endmodule

// File: rtl/bec_host_ctrl_p.sv
// Host-side controller for the BEC point-multiplication core: assembles
// operands from host words, pushes them to the core, serves the key
// bit-serially while the core runs, and streams result words back.
module bec_host_ctrl_p
    import bec_ctrl_pkg::*;
#(
    parameter int unsigned FIELD_W = 163,
    parameter int unsigned CHUNK_W = 64,
    parameter int unsigned NUM_OPS = 6,
    parameter int unsigned NUM_RES = 2,
    parameter int unsigned TIMEOUT = 65535
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_code,
    input  logic [CHUNK_W-1:0]           cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [CHUNK_W-1:0]           rsp_data,
    output logic [4:0]                   status,
    output logic                         bec_load_valid,
    input  logic                         bec_load_ready,
    output logic [idx_w(NUM_OPS)-1:0]    bec_load_idx,
    output logic [FIELD_W-1:0]           bec_load_data,
    output logic                         bec_ena_proc,
    output logic                         bec_key_bit,
    input  logic                         bec_next_key,
    input  logic                         bec_done,
    output logic [idx_w(NUM_RES)-1:0]    bec_res_sel,
    input  logic [FIELD_W-1:0]           bec_res_data
);

    localparam int unsigned NCHUNK  = nchunk(FIELD_W, CHUNK_W);
    localparam int unsigned CIDX_W  = idx_w(NCHUNK);
    localparam int unsigned OIDX_W  = idx_w(NUM_OPS);
    localparam int unsigned RSEL_W  = idx_w(NUM_RES);
    localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned LAST_LO = (NCHUNK - 1) * CHUNK_W;
    localparam int unsigned LAST_W  = FIELD_W - LAST_LO;

    state_e              r_state;
    state_e              w_state_nxt;
    err_e                r_err;
    logic [OIDX_W-1:0]   r_op_idx;
    logic [CIDX_W-1:0]   r_chunk_idx;
    logic [CIDX_W-1:0]   r_rd_idx;
    logic [FIELD_W-1:0]  r_asm;
    logic [FIELD_W-1:0]  r_key_sr;
    logic [FIELD_W-1:0]  r_cap;
    logic [WD_W-1:0]     r_wdog;
    logic [RSEL_W-1:0]   r_res_sel;

    logic                w_fire;
    logic                w_wr_ok;
    logic                w_start_ok;
    logic                w_rdq_ok;
    logic                w_abort;
    logic                w_bad_seq;
    logic                w_ovf;
    logic                w_push_hs;
    logic                w_push_last;
    logic                w_done_hit;
    logic                w_timeout;
    logic                w_rsp_hs;
    logic [CIDX_W-1:0]   w_wr_cidx;
    logic                w_wr_last;
    logic [FIELD_W-1:0]  w_wr_vec;
    logic [CHUNK_W-1:0]  w_wr_trunc;
    logic [FIELD_W-1:0]  w_asm_nxt;
    logic [CHUNK_W-1:0]  w_rd_chunk;
    logic                w_rd_last;

    // Result streaming: current chunk of the captured result.
    bec_chunk_unpacker #(
        .FIELD_W (FIELD_W),
        .CHUNK_W (CHUNK_W)
    ) u_rsp_unpack (
        .i_vec   (r_cap),
        .i_idx   (r_rd_idx),
        .o_chunk (w_rd_chunk),
        .o_last  (w_rd_last)
    );

    // Incoming word placed in the top chunk and read back through the
    // unpacker: the round trip drops bits above FIELD_W, so any difference
    // from cmd_data flags an overflow. Its last flag marks the final chunk.
    bec_chunk_unpacker #(
        .FIELD_W (FIELD_W),
        .CHUNK_W (CHUNK_W)
    ) u_ovf_check (
        .i_vec   (w_wr_vec),
        .i_idx   (w_wr_cidx),
        .o_chunk (w_wr_trunc),
        .o_last  (w_wr_last)
    );

    // Command decode and per-cycle event qualification.
    always_comb begin
        w_fire      = cmd_valid && cmd_ready;
        w_wr_ok     = w_fire && (cmd_code == CMD_WRITE_CHUNK) &&
                      (r_state inside {ST_LOAD, ST_ARMED, ST_DONE});
        w_start_ok  = w_fire && (cmd_code == CMD_START) && (r_state == ST_ARMED);
        w_rdq_ok    = w_fire && (cmd_code == CMD_READ_REQ) && (r_state == ST_DONE) &&
                      (cmd_data < CHUNK_W'(NUM_RES));
        w_abort     = w_fire && (cmd_code == CMD_ABORT);
        w_bad_seq   = w_fire && !w_abort && !w_wr_ok && !w_start_ok && !w_rdq_ok;
        // A write outside LOAD restarts the job, so it lands in chunk 0.
        w_wr_cidx   = (r_state == ST_LOAD) ? r_chunk_idx : '0;
        w_wr_vec    = '0;
        w_wr_vec[FIELD_W-1:LAST_LO] = cmd_data[LAST_W-1:0];
        w_ovf       = w_wr_ok && w_wr_last && (cmd_data != w_wr_trunc);
        w_push_hs   = (r_state == ST_PUSH) && bec_load_ready;
        w_push_last = (r_op_idx == OIDX_W'(NUM_OPS - 1));
        w_done_hit  = (r_state == ST_PROC) && bec_done && !w_abort;
        w_timeout   = (r_state == ST_PROC) && !bec_done && !w_abort &&
                      (r_wdog == WD_W'(TIMEOUT - 1));
        w_rsp_hs    = (r_state == ST_READ) && rsp_ready && !w_abort;
    end

    // Assembly register with the incoming word merged in.
    always_comb begin
        w_asm_nxt = r_asm;
        for (int unsigned k = 0; k + 1 < NCHUNK; k++) begin
            if (w_wr_cidx == CIDX_W'(k)) begin
                w_asm_nxt[k*CHUNK_W +: CHUNK_W] = cmd_data;
            end
        end
        if (w_wr_last) begin
            w_asm_nxt[FIELD_W-1:LAST_LO] = cmd_data[LAST_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD, ST_ARMED, ST_DONE: begin
                    if (w_wr_ok) begin
                        w_state_nxt = w_wr_last ? ST_PUSH : ST_LOAD;
                    end else if (w_start_ok) begin
                        w_state_nxt = ST_PROC;
                    end else if (w_rdq_ok) begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
                ST_PUSH: begin
                    if (w_push_hs) begin
                        w_state_nxt = w_push_last ? ST_ARMED : ST_LOAD;
                    end
                end
                ST_PROC: begin
                    if (w_done_hit) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_timeout) begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_CAPTURE: w_state_nxt = ST_READ;
                ST_READ: begin
                    if (w_rsp_hs && w_rd_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: w_state_nxt = ST_LOAD;
            endcase
        end
    end

    // Output decode from state and datapath registers.
    always_comb begin
        cmd_ready      = !(r_state inside {ST_PUSH, ST_CAPTURE});
        bec_load_valid = (r_state == ST_PUSH);
        bec_load_idx   = (r_state == ST_PUSH) ? r_op_idx : '0;
        bec_load_data  = (r_state == ST_PUSH) ? r_asm : '0;
        bec_ena_proc   = (r_state == ST_PROC);
        bec_key_bit    = (r_state == ST_PROC) && r_key_sr[0];
        bec_res_sel    = r_res_sel;
        rsp_valid      = (r_state == ST_READ);
        rsp_data       = (r_state == ST_READ) ? w_rd_chunk : '0;
        status         = {r_err, r_state};
    end

    // Operand assembly, counters, key shifter, watchdog and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_idx    <= '0;
            r_chunk_idx <= '0;
            r_rd_idx    <= '0;
            r_asm       <= '0;
            r_key_sr    <= '0;
            r_cap       <= '0;
            r_wdog      <= '0;
            r_res_sel   <= '0;
        end else begin
            if (w_abort || w_timeout) begin
                r_op_idx    <= '0;
                r_chunk_idx <= '0;
                r_rd_idx    <= '0;
            end else begin
                if (w_wr_ok) begin
                    r_asm       <= w_asm_nxt;
                    r_chunk_idx <= w_wr_last ? '0 : w_wr_cidx + CIDX_W'(1);
                    if (r_state != ST_LOAD) begin
                        r_op_idx <= '0;
                    end
                end
                if (w_push_hs) begin
                    r_op_idx <= w_push_last ? '0 : r_op_idx + OIDX_W'(1);
                    if (w_push_last) begin
                        r_key_sr <= r_asm;
                    end
                end
                if (w_rdq_ok) begin
                    r_res_sel <= cmd_data[RSEL_W-1:0];
                end
                if (r_state == ST_CAPTURE) begin
                    r_cap    <= bec_res_data;
                    r_rd_idx <= '0;
                end
                if (w_rsp_hs) begin
                    r_rd_idx <= w_rd_last ? '0 : r_rd_idx + CIDX_W'(1);
                end
            end
            if (w_start_ok) begin
                r_wdog <= '0;
            end else if (r_state == ST_PROC) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            if ((r_state == ST_PROC) && bec_next_key) begin
                r_key_sr <= r_key_sr >> 1;
            end
        end
    end

    // Sticky error code; the latest error wins, ABORT clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= ERR_NONE;
        end else if (w_abort) begin
            r_err <= ERR_NONE;
        end else if (w_timeout) begin
            r_err <= ERR_TIMEOUT;
        end else if (w_bad_seq) begin
            r_err <= ERR_BAD_SEQ;
        end else if (w_ovf) begin
            r_err <= ERR_OVF;
        end
    end

endmodule

// File: tb/tb_bec_host_ctrl_p.sv
// Scoreboard bench for bec_host_ctrl_p: expected pushes and result chunks
// are queued by the stimulus and checked by independent monitors.
module tb_bec_host_ctrl_p;

    localparam int FW   = 163;
    localparam int CW   = 64;
    localparam int NOPS = 6;
    localparam int NRES = 2;
    localparam int TMO  = 16;

    logic           clk;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_code;
    logic [CW-1:0]  cmd_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [CW-1:0]  rsp_data;
    logic [4:0]     status;
    logic           bec_load_valid;
    logic           bec_load_ready;
    logic [2:0]     bec_load_idx;
    logic [FW-1:0]  bec_load_data;
    logic           bec_ena_proc;
    logic           bec_key_bit;
    logic           bec_next_key;
    logic           bec_done;
    logic [0:0]     bec_res_sel;
    logic [FW-1:0]  bec_res_data;

    localparam logic [FW-1:0] PAT0 = {35'h1_2345_6789, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    localparam logic [FW-1:0] ALL1 = '1;

    typedef struct {
        logic [2:0]    idx;
        logic [FW-1:0] data;
    } load_t;

    load_t         load_q[$];
    logic [CW-1:0] rsp_q[$];
    logic [CW-1:0] ch[NOPS][3];
    int            n_pass;
    int            n_checks;

    bec_host_ctrl_p #(
        .FIELD_W (FW),
        .CHUNK_W (CW),
        .NUM_OPS (NOPS),
        .NUM_RES (NRES),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_code       (cmd_code),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .status         (status),
        .bec_load_valid (bec_load_valid),
        .bec_load_ready (bec_load_ready),
        .bec_load_idx   (bec_load_idx),
        .bec_load_data  (bec_load_data),
        .bec_ena_proc   (bec_ena_proc),
        .bec_key_bit    (bec_key_bit),
        .bec_next_key   (bec_next_key),
        .bec_done       (bec_done),
        .bec_res_sel    (bec_res_sel),
        .bec_res_data   (bec_res_data)
    );

    // Core result mux stand-in: slot 1 is all ones, slot 0 a fixed pattern.
    assign bec_res_data = (bec_res_sel == 1'b1) ? ALL1 : PAT0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] code, input logic [CW-1:0] data);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_data  = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept", ok, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_code  = '0;
        cmd_data  = '0;
    endtask

    task automatic load_op(input int idx, input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                           input logic [CW-1:0] c2, input bit stall);
        load_t e;
        e.idx  = idx[2:0];
        e.data = {c2[34:0], c1, c0};
        load_q.push_back(e);
        send_cmd(2'd0, c0);
        send_cmd(2'd0, c1);
        if (stall) bec_load_ready = 1'b0;
        send_cmd(2'd0, c2);
        if (stall) begin
            repeat (4) begin
                @(negedge clk);
                check("stall_valid", bec_load_valid, 1);
                check("stall_idx", bec_load_idx, e.idx);
                check("stall_data", bec_load_data, e.data);
                @(posedge clk);
                #1;
            end
            bec_load_ready = 1'b1;
        end
    endtask

    task automatic load_all(input int stall_op);
        for (int i = 0; i < NOPS; i++) begin
            load_op(i, ch[i][0], ch[i][1], ch[i][2], i == stall_op);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input string name);
        for (int i = 0; i < 20; i++) begin
            if (status[2:0] == st) break;
            tick();
        end
        check(name, status[2:0], st);
    endtask

    // Operand push monitor.
    always @(negedge clk) begin
        load_t e;
        if (!rst && bec_load_valid && bec_load_ready) begin
            if (load_q.size() == 0) begin
                check("load_unexpected", bec_load_idx, 3'h7);
            end else begin
                e = load_q.pop_front();
                check("load_idx", bec_load_idx, e.idx);
                check("load_data", bec_load_data, e.data);
            end
        end
    end

    // Result chunk monitor.
    always @(negedge clk) begin
        logic [CW-1:0] exp;
        if (!rst && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                exp = rsp_q.pop_front();
                check("rsp_data", rsp_data, exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        n_pass         = 0;
        n_checks       = 0;
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_code       = '0;
        cmd_data       = '0;
        rsp_ready      = 1'b0;
        bec_load_ready = 1'b1;
        bec_next_key   = 1'b0;
        bec_done       = 1'b0;
        for (int i = 0; i < NOPS; i++) begin
            ch[i][0] = 64'h0123_4567_0000_0000 | 64'(i);
            ch[i][1] = 64'hCAFE_0000_0000_0000 | (64'(i) << 8);
            ch[i][2] = 64'h0000_0005_5555_5550 | 64'(i);
        end
        ch[NOPS-1][0] = 64'h5;
        ch[NOPS-1][1] = 64'h0;
        ch[NOPS-1][2] = 64'h0;

        // Reset values.
        #3;
        check("rst_status", status, 5'b00_000);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_outs", {rsp_valid, bec_load_valid, bec_ena_proc, bec_key_bit, bec_res_sel}, 5'b0);
        check("rst_data", {rsp_data, bec_load_data, bec_load_idx}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Full load with a 4-cycle stall on operand 2.
        load_all(2);
        wait_state(3'd2, "armed_state");
        check("armed_status", status, 5'b00_010);
        check("load_q_drained", load_q.size(), 0);

        // Run with key 5: bits 1,0,1,0.
        send_cmd(2'd1, '0);
        check("proc_status", status, 5'b00_011);
        check("proc_ena", bec_ena_proc, 1);
        check("key_bit_0", bec_key_bit, 1);
        for (int p = 0; p < 3; p++) begin
            bec_next_key = 1'b1;
            tick();
            bec_next_key = 1'b0;
            check("key_bit_n", bec_key_bit, (p == 1) ? 1 : 0);
        end
        bec_done = 1'b1;
        tick();
        bec_done = 1'b0;
        check("done_status", status, 5'b00_110);
        check("done_ena", bec_ena_proc, 0);

        // Read result 1 with a 2-cycle stall after chunk 0.
        rsp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        rsp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        rsp_q.push_back(64'h0000_0007_FFFF_FFFF);
        send_cmd(2'd2, 64'd1);
        check("capture_status", status, 5'b00_100);
        check("capture_sel", bec_res_sel, 1);
        check("capture_cmd_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        tick();
        check("read_status", status, 5'b00_101);
        tick();
        rsp_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        wait_state(3'd6, "read_done_state");
        check("read_done_valid", rsp_valid, 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        rsp_ready = 1'b0;

        // Bad index, then ABORT, then START outside ARMED.
        send_cmd(2'd2, 64'd2);
        check("bad_idx_status", status, 5'b01_110);
        send_cmd(2'd3, '0);
        check("abort_status", status, 5'b00_000);
        send_cmd(2'd1, '0);
        check("start_in_load", status, 5'b01_000);

        // Overflowing last chunk on operand 0; extra bits are dropped.
        load_op(0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h8000_0000_0000_0000, 1'b0);
        check("ovf_status", status, 5'b10_001);
        for (int i = 1; i < NOPS; i++) begin
            load_op(i, ch[i][0], ch[i][1], ch[i][2], 1'b0);
        end
        wait_state(3'd2, "armed2_state");
        check("armed2_status", status, 5'b10_010);

        // Watchdog expiry after TMO processing cycles.
        send_cmd(2'd1, '0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bec_ena_proc) n++;
            else break;
        end
        check("proc_cycles", n, TMO);
        check("timeout_status", status, 5'b11_000);
        check("timeout_ena", bec_ena_proc, 0);
        tick();
        send_cmd(2'd3, '0);
        check("abort2_status", status, 5'b00_000);

        // Asynchronous reset while streaming result 0.
        load_all(-1);
        wait_state(3'd2, "armed3_state");
        send_cmd(2'd1, '0);
        bec_done = 1'b1;
        tick();
        bec_done = 1'b0;
        check("done3_status", status, 5'b00_110);
        send_cmd(2'd2, 64'd0);
        tick();
        check("read3_status", status, 5'b00_101);
        check("read3_data", rsp_data, 64'hFEDC_BA98_7654_3210);
        #2;
        rst = 1'b1;
        #1;
        check("arst_status", status, 5'b00_000);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_outs", {rsp_valid, bec_load_valid, bec_ena_proc, bec_key_bit, bec_res_sel}, 5'b0);
        check("arst_data", {rsp_data, bec_load_data, bec_load_idx}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_status", status, 5'b00_000);
        check("load_q_final", load_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
